position_read_arbiter: RTL
==========================

Name: position_read_arbiter

Overview:
- Shares the single read port of the position cache among N_REQ requesters (pair-filter / neighbour-fetch pipelines) with round-robin fairness.
- Registers the winning request onto the cache port and tracks each read through the fixed-latency memory pipeline.
- Routes returned data to the requester that issued it.
- Exports `in_flight` so the upstream position-read sequencing logic can tell when the position cache has drained between batches.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, position cache address width.
- DATA_W, 96, position word width (3 x 32-bit x/y/z).
- RD_LATENCY, 2, cycles from `mem_rd_en` high to `mem_rd_data` valid (1..4).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = new grants allowed; 0 = no new grants, in-flight reads still complete.
- req_valid  in  N_REQ  per-requester read request.
- req_addr  in  N_REQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
- req_ready  out  N_REQ  one-hot grant (combinational); a read is accepted when req_valid[i] & req_ready[i] in the same cycle.
- mem_rd_en  out  1  registered read strobe to the position cache.
- mem_rd_addr  out  ADDR_W  registered read address.
- mem_rd_data  in  DATA_W  cache read data, valid RD_LATENCY cycles after mem_rd_en.
- resp_valid  out  N_REQ  registered one-hot response strobe.
- resp_data  out  DATA_W  registered response data, shared by all requesters.
- in_flight  out  1  registered; 1 while any accepted read has not yet produced resp_valid.
- reads_issued  out  16  count of accepted reads; wraps at 65535 -> 0.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs below go to 0 and stay 0 until the first rising edge after reset_n rises.
  - mem_rd_en, mem_rd_addr, resp_valid, resp_data, in_flight, reads_issued = 0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - Tracking pipeline cleared.
- Reset mid-operation: all pending reads are dropped and no response is ever produced for them.
- Grant (combinational):
  - No grant when enable = 0; req_ready = 0.
  - Otherwise search from pointer+1 upward, wrapping modulo N_REQ; the first i with req_valid[i] = 1 gets req_ready[i] = 1.
  - At most one grant per cycle; req_ready = 0 when no request is valid.
  - Requesters hold req_valid and req_addr until granted. Withdrawing a request before grant is tolerated and has no side effect.
- Pointer update: on accept, the pointer moves to the granted index; otherwise it is unchanged.
- Issue: a read accepted in cycle k drives mem_rd_en = 1 and mem_rd_addr = req_addr[granted] in cycle k+1. Back-to-back accepts give a continuous mem_rd_en, one read per cycle.
- Tracking: a shift register of depth RD_LATENCY carries {valid, requester id} alongside each read.
- Response: for a read accepted in cycle k:
  - mem_rd_data is sampled in cycle k+1+RD_LATENCY.
  - resp_valid[id] = 1 and resp_data = that data in cycle k+2+RD_LATENCY.
  - Total latency is RD_LATENCY+2.
  - Responses are never stalled; requesters must accept them.
  - resp_data holds its last value when resp_valid = 0.
- Outstanding count: width clog2(RD_LATENCY+3).
  - +1 on accept, -1 on each cycle with resp_valid != 0.
  - Simultaneous accept and response leaves the count unchanged.
  - in_flight is registered (count_next != 0).
- in_flight timing: in_flight rises in cycle k+1 after a single accept in cycle k, and falls in the cycle after the last resp_valid.
- enable falling mid-stream: no new accepts from the next cycle on; the pipeline drains normally.
- enable toggling does not reset the round-robin pointer.

Decomposition:
- Package md_pos_pkg holds:
  - POS_ADDR_W = 10, POS_DATA_W = 96.
  - Position word typedef with x/y/z 32-bit fields.
  - Function clog2.
- Sub-module rr_arbiter_n holds the combinational round-robin grant plus the registered pointer.
  - Parameter N; inputs req, advance; output one-hot grant.
  - Reused by later force-write arbitration.

Test Plan:
- Reset, then a single request: requester 2 requests addr 0x015 at k=5, RD_LATENCY=2.
  - mem_rd_en high in cycle 6 only, addr 0x015.
  - Model returns D in cycle 8; resp_valid = 4'b0100 with resp_data = D in cycle 9.
  - in_flight high in cycles 6-9, low in cycle 10; reads_issued = 1.
- All four requesters held valid for 8 cycles:
  - Grants are 0,1,2,3,0,1,2,3, one per cycle.
  - mem_rd_en continuous for 8 cycles.
  - Each response goes to the matching requester with the matching data, in order.
- enable dropped while 2 reads are outstanding:
  - No further req_ready.
  - Both responses are still delivered.
  - in_flight falls one cycle after the second resp_valid.
- reset_n pulsed low for one cycle, mid-edge, with 3 reads in the pipeline:
  - All outputs go to 0 immediately and asynchronously.
  - No resp_valid afterwards; the next grant goes to requester 0.
- Accept and response in the same cycle under steady one-per-cycle traffic:
  - The outstanding count stays at RD_LATENCY+2.
  - in_flight stays 1.
- 65536 accepts: reads_issued wraps to 0.

Source files
------------

// File: rtl/md_pos_pkg.sv
// Shared position-cache definitions: widths, the x/y/z position word and a
// constant-friendly ceil(log2) helper used for sizing ids and counters.
package md_pos_pkg;

  localparam int POS_ADDR_W = 10;
  localparam int POS_DATA_W = 96;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] y;
    logic [31:0] x;
  } pos_word_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: combinational one-hot grant searched upward from the
// last winner, plus the registered last-winner pointer.
module rr_arbiter_n
  import md_pos_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] grant_idx;
  logic          found;

  // off runs 1..N so the previous winner is visited last.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    sel       = '0;
    for (int off = 1; off <= N; off++) begin
      sel = PW'((int'(ptr) + off) % N);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= PW'(N - 1);
    end else if (advance && found) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/position_read_arbiter.sv
// Shares the position cache read port among N_REQ requesters, issues the
// winning read one cycle later and routes the returned word back to its owner.
module position_read_arbiter
  import md_pos_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = POS_ADDR_W,
  parameter int DATA_W     = POS_DATA_W,
  parameter int RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [DATA_W-1:0]       mem_rd_data,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    in_flight,
  output logic [15:0]             reads_issued
);

  localparam int ID_W  = clog2(N_REQ);
  localparam int CNT_W = clog2(RD_LATENCY + 3);

  // Handshake: a read transfers when req_valid[i] & req_ready[i] are both high
  // in the same cycle; the requester holds req_valid/req_addr until then, and
  // responses are strobed on resp_valid with no back-pressure.

  logic [N_REQ-1:0]  req_masked;
  logic              accept;
  logic [ID_W-1:0]   grant_id;
  logic [ADDR_W-1:0] grant_addr;
  logic [ID_W-1:0]   issue_id;
  logic              trk_valid [RD_LATENCY];
  logic [ID_W-1:0]   trk_id    [RD_LATENCY];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  assign req_masked = enable ? req_valid : '0;
  assign accept     = |req_ready;

  rr_arbiter_n #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_masked),
    .advance (accept),
    .grant   (req_ready)
  );

  always_comb begin
    grant_id   = '0;
    grant_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        grant_id   = ID_W'(i);
        grant_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      issue_id    <= '0;
    end else begin
      mem_rd_en <= accept;
      if (accept) begin
        mem_rd_addr <= grant_addr;
        issue_id    <= grant_id;
      end
    end
  end

  // Stage j holds the read whose strobe was j+1 cycles ago, so the last stage
  // lines up with mem_rd_data being valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < RD_LATENCY; j++) begin
        trk_valid[j] <= 1'b0;
        trk_id[j]    <= '0;
      end
    end else begin
      trk_valid[0] <= mem_rd_en;
      trk_id[0]    <= issue_id;
      for (int j = 1; j < RD_LATENCY; j++) begin
        trk_valid[j] <= trk_valid[j-1];
        trk_id[j]    <= trk_id[j-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (trk_valid[RD_LATENCY-1]) begin
      resp_valid <= N_REQ'(1) << trk_id[RD_LATENCY-1];
      resp_data  <= mem_rd_data;
    end else begin
      resp_valid <= '0;
    end
  end

  always_comb begin
    count_next = count;
    if (accept)      count_next = count_next + CNT_W'(1);
    if (|resp_valid) count_next = count_next - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      in_flight    <= 1'b0;
      reads_issued <= '0;
    end else begin
      count        <= count_next;
      in_flight    <= (count_next != '0);
      reads_issued <= reads_issued + 16'(accept);
    end
  end

endmodule
